// File: rtl/fast_pmap_encoder.sv
// FAST message encoder front end: classifies fields per operator, builds the stop-bit encoded
// presence map, emits dictionary write-backs and streams pmap bytes then field words.
module fast_pmap_encoder #(
  parameter int unsigned beat_width = 64,
  parameter int unsigned max_fields = 10,
  parameter int unsigned op_width   = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [$clog2(max_fields+1)-1:0] num_fields,
  input  logic [op_width-1:0]           op         [max_fields],
  input  logic [beat_width-1:0]         value      [max_fields],
  input  logic [beat_width-1:0]         prev       [max_fields],
  input  logic [max_fields-1:0]         prev_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_kind,
  output logic [$clog2(max_fields)-1:0] out_idx,
  output logic [beat_width-1:0]         out_data,
  output logic                          out_last,
  output logic                          dict_we,
  output logic [$clog2(max_fields)-1:0] dict_idx,
  output logic [beat_width-1:0]         dict_data,
  output logic                          busy,
  output logic                          done,
  output logic                          op_err
);

  localparam int unsigned NumW  = $clog2(max_fields + 1);
  localparam int unsigned IdxW  = $clog2(max_fields);
  localparam int unsigned PmapW = 7 * ((max_fields + 6) / 7);

  localparam logic [NumW-1:0]     MaxN    = NumW'(max_fields);
  localparam logic [PmapW-1:0]    PtrInit = {1'b1, {(PmapW-1){1'b0}}};
  localparam logic [op_width-1:0] OpNone  = op_width'(0);
  localparam logic [op_width-1:0] OpConst = op_width'(1);
  localparam logic [op_width-1:0] OpCopy  = op_width'(2);
  localparam logic [op_width-1:0] OpDflt  = op_width'(3);
  localparam logic [op_width-1:0] OpDelta = op_width'(4);
  localparam logic [op_width-1:0] OpIncr  = op_width'(5);
  localparam logic [op_width-1:0] OpTail  = op_width'(6);

  typedef enum logic [1:0] {StIdle, StScan, StPmap, StField} state_e;

  state_e                  state_q;
  logic [NumW-1:0]         n_q, pcnt_q, byte_q;
  logic [IdxW-1:0]         scan_idx_q;
  logic [op_width-1:0]     op_q    [max_fields];
  logic [beat_width-1:0]   val_q   [max_fields];
  logic [beat_width-1:0]   prev_q  [max_fields];
  logic [max_fields-1:0]   pv_q, emit_q;
  logic [PmapW-1:0]        pm_q, ptr_q;
  logic                    done_q, err_q;

  logic [NumW-1:0]         n_clamped;
  logic [op_width-1:0]     c_op;
  logic [beat_width-1:0]   c_val, c_prev, p_eff, emit_data;
  logic                    c_pv, uses_pbit, pbit, emit, upd, bad_op;
  logic                    last_scan, last_byte, last_field;
  logic [IdxW-1:0]         cur_idx;
  int unsigned             n_bytes;

  assign n_clamped = (num_fields > MaxN) ? MaxN : num_fields;
  assign last_scan = (NumW'(scan_idx_q) + NumW'(1)) == n_q;

  // Per-field operator decode for the field currently being scanned.
  always_comb begin
    c_op      = op_q[scan_idx_q];
    c_val     = val_q[scan_idx_q];
    c_prev    = prev_q[scan_idx_q];
    c_pv      = pv_q[scan_idx_q];
    p_eff     = c_pv ? c_prev : '0;
    uses_pbit = 1'b0;
    pbit      = 1'b0;
    emit      = 1'b0;
    upd       = 1'b0;
    bad_op    = 1'b0;
    emit_data = c_val;
    case (c_op)
      OpNone:  emit = 1'b1;
      OpConst: ;
      OpCopy, OpTail: begin
        uses_pbit = 1'b1;
        pbit      = !c_pv || (c_val != c_prev);
        emit      = pbit;
        upd       = pbit;
      end
      OpDflt: begin
        uses_pbit = 1'b1;
        pbit      = c_val != c_prev;
        emit      = pbit;
      end
      OpDelta: begin
        emit      = 1'b1;
        emit_data = c_val - p_eff;
        upd       = 1'b1;
      end
      OpIncr: begin
        uses_pbit = 1'b1;
        pbit      = !(c_pv && (c_val == c_prev + beat_width'(1)));
        emit      = pbit;
        upd       = 1'b1;
      end
      default: begin
        emit   = 1'b1;
        bad_op = 1'b1;
      end
    endcase
  end

  // Output side: pmap byte position and lowest remaining emitted field.
  always_comb begin
    n_bytes = (32'(pcnt_q) + 32'd6) / 32'd7;
    if (n_bytes == 0) n_bytes = 1;
    last_byte = (32'(byte_q) + 32'd1) >= n_bytes;
    cur_idx = '0;
    for (int i = max_fields - 1; i >= 0; i--) begin
      if (emit_q[i]) cur_idx = IdxW'(i);
    end
    last_field = (emit_q & (emit_q - {{(max_fields-1){1'b0}}, 1'b1})) == '0;
  end

  always_comb begin
    out_valid = 1'b0;
    out_kind  = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == StPmap) begin
      out_valid = 1'b1;
      out_data  = {{(beat_width-8){1'b0}}, last_byte, pm_q[PmapW-1 -: 7]};
      out_last  = last_byte && (emit_q == '0);
    end else if (state_q == StField) begin
      out_valid = 1'b1;
      out_kind  = 1'b1;
      out_idx   = cur_idx;
      out_data  = val_q[cur_idx];
      out_last  = last_field;
    end
  end

  assign dict_we   = (state_q == StScan) && upd;
  assign dict_idx  = dict_we ? scan_idx_q : '0;
  assign dict_data = dict_we ? c_val : '0;
  assign busy      = state_q != StIdle;
  assign done      = done_q;
  assign op_err    = err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      n_q        <= '0;
      pcnt_q     <= '0;
      byte_q     <= '0;
      scan_idx_q <= '0;
      pv_q       <= '0;
      emit_q     <= '0;
      pm_q       <= '0;
      ptr_q      <= PtrInit;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < max_fields; i++) begin
        op_q[i]   <= '0;
        val_q[i]  <= '0;
        prev_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: if (start) begin
          op_q       <= op;
          val_q      <= value;
          prev_q     <= prev;
          pv_q       <= prev_valid;
          n_q        <= n_clamped;
          scan_idx_q <= '0;
          pcnt_q     <= '0;
          byte_q     <= '0;
          pm_q       <= '0;
          ptr_q      <= PtrInit;
          emit_q     <= '0;
          if (num_fields > MaxN) err_q <= 1'b1;
          state_q <= (n_clamped == '0) ? StPmap : StScan;
        end
        StScan: begin
          if (uses_pbit) begin
            if (pbit) pm_q <= pm_q | ptr_q;
            ptr_q  <= ptr_q >> 1;
            pcnt_q <= pcnt_q + NumW'(1);
          end
          if (emit) emit_q[scan_idx_q] <= 1'b1;
          // Field word payload replaces the snapshot (only differs for DELTA).
          val_q[scan_idx_q] <= emit_data;
          if (bad_op) err_q <= 1'b1;
          if (last_scan) state_q <= StPmap;
          else           scan_idx_q <= scan_idx_q + IdxW'(1);
        end
        StPmap: if (out_ready) begin
          pm_q   <= pm_q << 7;
          byte_q <= byte_q + NumW'(1);
          if (last_byte) begin
            if (emit_q != '0) begin
              state_q <= StField;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StField: if (out_ready) begin
          emit_q <= emit_q & (emit_q - {{(max_fields-1){1'b0}}, 1'b1});
          if (last_field) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
